// File: rtl/reescalador_par_if.sv
// Stream bundle for the rescaler: coefficient input beats and rescaled output beats.
// Both directions use valid/ready; a beat transfers on a rising edge where valid and ready are both high.
interface reescalador_par_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 24,
    parameter int LANES = 1
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_coef;
    logic [5:0]             in_qp;
    logic                   in_dc;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_coef;
    logic                   out_last;
    logic                   out_sat;

    modport slave (
        input  in_valid, in_coef, in_qp, in_dc, out_ready,
        output in_ready, out_valid, out_coef, out_last, out_sat
    );

    modport master (
        output in_valid, in_coef, in_qp, in_dc, out_ready,
        input  in_ready, out_valid, out_coef, out_last, out_sat
    );
endinterface

// File: rtl/reescalador_par.sv
// H.264 inverse-quantisation rescaler for 4x4 blocks, LANES coefficients per beat,
// AC or Intra16x16 luma-DC mode, two-stage stallable pipeline with output saturation.
module reescalador_par #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 24,
    parameter int LANES = 1
) (
    input  logic              clk,
    input  logic              rst,
    reescalador_par_if.slave  bus
);
    localparam int BEATS = 16 / LANES;
    localparam int PW    = IN_W + 6;
    localparam int WI    = IN_W + 14;
    localparam int WX    = ((WI > OUT_W) ? WI : OUT_W) + 1;
    localparam logic signed [WX-1:0] SAT_MAX = {{(WX-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WX-1:0] SAT_MIN = {{(WX-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [3:0]             r_bcnt;
    logic [5:0]             r_qp;
    logic                   r_dc;
    logic                   r_s1_valid;
    logic                   r_s1_dc;
    logic                   r_s1_last;
    logic [3:0]             r_s1_e;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic                   r_out_sat;
    logic [LANES*OUT_W-1:0] r_out_coef;

    logic                   w_s2_move;
    logic                   w_in_ready;
    logic                   w_in_fire;
    logic                   w_first;
    logic                   w_last;
    logic [5:0]             w_qp_in;
    logic [5:0]             w_qp;
    logic                   w_dc;
    logic [2:0]             w_m;
    logic [3:0]             w_e;
    logic [LANES*OUT_W-1:0] w_d_pack;
    logic [LANES-1:0]       w_sat;

    // Packed {v0,v1,v2} per qp%6; k selects the position class (0,1,2).
    function automatic logic [4:0] f_vtab(input logic [2:0] m, input logic [1:0] k);
        logic [14:0] w_row;
        case (m)
            3'd0:    w_row = {5'd10, 5'd16, 5'd13};
            3'd1:    w_row = {5'd11, 5'd18, 5'd14};
            3'd2:    w_row = {5'd13, 5'd20, 5'd16};
            3'd3:    w_row = {5'd14, 5'd23, 5'd18};
            3'd4:    w_row = {5'd16, 5'd25, 5'd20};
            default: w_row = {5'd18, 5'd29, 5'd23};
        endcase
        case (k)
            2'd0:    return w_row[14:10];
            2'd1:    return w_row[9:5];
            default: return w_row[4:0];
        endcase
    endfunction

    // Stage 2 drains when downstream takes it or it is empty; stage 1 loads when it is empty or drains.
    assign w_s2_move  = bus.out_ready | ~r_out_valid;
    assign w_in_ready = ~r_s1_valid | w_s2_move;
    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_first    = (r_bcnt == 4'd0);
    assign w_last     = (r_bcnt == 4'(BEATS - 1));
    assign w_qp_in    = (bus.in_qp > 6'd51) ? 6'd51 : bus.in_qp;
    assign w_qp       = w_first ? w_qp_in : r_qp;
    assign w_dc       = w_first ? bus.in_dc : r_dc;
    assign w_m        = 3'(w_qp % 6);
    assign w_e        = 4'(w_qp / 6);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [3:0]             w_pos;
        logic [1:0]             w_cls;
        logic [4:0]             w_v;
        logic [IN_W-1:0]        w_c;
        logic signed [PW-1:0]   w_cx;
        logic signed [PW-1:0]   w_vx;
        logic signed [PW-1:0]   w_prod;
        logic signed [PW-1:0]   r_prod;
        logic signed [WI-1:0]   w_ext;
        logic signed [WI-1:0]   w_shl;
        logic signed [WI-1:0]   w_rnd;
        logic signed [WI-1:0]   w_res;
        logic signed [WX-1:0]   w_wide;
        logic [OUT_W-1:0]       w_ld;
        logic                   w_lsat;

        assign w_pos  = 4'(r_bcnt * LANES + l);
        assign w_cls  = (w_dc || (!w_pos[2] && !w_pos[0])) ? 2'd0 :
                        (w_pos[2] && w_pos[0])             ? 2'd1 : 2'd2;
        assign w_v    = f_vtab(w_m, w_cls);
        assign w_c    = bus.in_coef[l*IN_W +: IN_W];
        assign w_cx   = {{6{w_c[IN_W-1]}}, w_c};
        assign w_vx   = {{(PW-6){1'b0}}, 1'b0, w_v};
        assign w_prod = w_cx * w_vx;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_prod <= '0;
            end else if (w_in_fire) begin
                r_prod <= w_prod;
            end
        end

        always_comb begin
            w_ext  = {{(WI-PW){r_prod[PW-1]}}, r_prod};
            w_shl  = w_ext <<< r_s1_e;
            w_rnd  = w_ext + ((r_s1_e == 4'd0) ? WI'(2) : WI'(1));
            if (!r_s1_dc) begin
                w_res = w_shl;
            end else if (r_s1_e >= 4'd2) begin
                w_res = w_shl >>> 2;
            end else begin
                w_res = w_rnd >>> ((r_s1_e == 4'd0) ? 2 : 1);
            end
            w_wide = {{(WX-WI){w_res[WI-1]}}, w_res};
            w_ld   = w_wide[OUT_W-1:0];
            w_lsat = 1'b0;
            if (w_wide > SAT_MAX) begin
                w_ld   = SAT_MAX[OUT_W-1:0];
                w_lsat = 1'b1;
            end else if (w_wide < SAT_MIN) begin
                w_ld   = SAT_MIN[OUT_W-1:0];
                w_lsat = 1'b1;
            end
        end

        assign w_d_pack[l*OUT_W +: OUT_W] = w_ld;
        assign w_sat[l]                   = w_lsat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt      <= 4'd0;
            r_qp        <= 6'd0;
            r_dc        <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_dc     <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_e      <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_sat   <= 1'b0;
            r_out_coef  <= '0;
        end else begin
            if (w_in_fire) begin
                r_bcnt    <= w_last ? 4'd0 : r_bcnt + 4'd1;
                r_s1_dc   <= w_dc;
                r_s1_e    <= w_e;
                r_s1_last <= w_last;
                if (w_first) begin
                    r_qp <= w_qp_in;
                    r_dc <= bus.in_dc;
                end
            end
            if (w_in_ready) begin
                r_s1_valid <= bus.in_valid;
            end
            if (w_s2_move) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_coef <= w_d_pack;
                    r_out_last <= r_s1_last;
                    r_out_sat  <= |w_sat;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_coef  = r_out_coef;
    assign bus.out_last  = r_out_last;
    assign bus.out_sat   = r_out_sat;
endmodule

// File: tb/tb_reescalador_par.sv
// Bench for reescalador_par: one LANES=1/OUT_W=16 instance and one LANES=4/OUT_W=24 instance,
// scored against an arithmetic model of the rescaling rules.
module tb_reescalador_par;
    localparam int IW  = 16;
    localparam int OWA = 16;
    localparam int OWB = 24;
    localparam int V_TAB [6][3] = '{'{10, 16, 13}, '{11, 18, 14}, '{13, 20, 16},
                                    '{14, 23, 18}, '{16, 25, 20}, '{18, 29, 23}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reescalador_par_if #(.IN_W(IW), .OUT_W(OWA), .LANES(1)) bus_a ();
    reescalador_par_if #(.IN_W(IW), .OUT_W(OWB), .LANES(4)) bus_b ();

    reescalador_par #(.IN_W(IW), .OUT_W(OWA), .LANES(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    reescalador_par #(.IN_W(IW), .OUT_W(OWB), .LANES(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rdy_mode_a = 0;   // 0 always ready, 1 random, 2 held low
    int rdy_mode_b = 0;
    int beat_a = 0, beat_b = 0, acc_b = 0;
    int blk_qp_a = 0, blk_qp_b = 0;
    bit blk_dc_a = 0, blk_dc_b = 0;
    int acc_cyc_a = 0;

    logic [17:0] exp_q_a[$];
    logic [17:0] obs_a[$];
    int          obs_cyc_a[$];
    logic [97:0] exp_q_b[$];
    logic [97:0] obs_b[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic void model(input longint c, input int p, input int qp_in, input bit dc,
                                  input int ow, output longint d, output bit s);
        int qp, m, e, v, r, k;
        longint lim;
        qp = (qp_in > 51) ? 51 : qp_in;
        m  = qp % 6;
        e  = qp / 6;
        r  = p / 4;
        k  = p % 4;
        if (dc || (r % 2 == 0 && k % 2 == 0)) v = V_TAB[m][0];
        else if (r % 2 == 1 && k % 2 == 1)    v = V_TAB[m][1];
        else                                  v = V_TAB[m][2];
        if (!dc)         d = c * v * (longint'(1) << e);
        else if (e >= 2) d = floor_div(c * v * (longint'(1) << e), 4);
        else             d = floor_div(c * v + (longint'(1) << (1 - e)), longint'(1) << (2 - e));
        lim = longint'(1) << (ow - 1);
        s = 1'b0;
        if (d > lim - 1) begin
            d = lim - 1;
            s = 1'b1;
        end else if (d < -lim) begin
            d = -lim;
            s = 1'b1;
        end
    endfunction

    // Downstream ready generators, updated just after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        bus_a.out_ready = (rdy_mode_a == 0) ? 1'b1 : (rdy_mode_a == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_b.out_ready = (rdy_mode_b == 0) ? 1'b1 : (rdy_mode_b == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    always @(negedge clk) begin
        logic [17:0] got_a;
        logic [97:0] got_b;
        if (!rst && bus_a.out_valid && bus_a.out_ready) begin
            got_a = {bus_a.out_last, bus_a.out_sat, bus_a.out_coef};
            obs_a.push_back(got_a);
            obs_cyc_a.push_back(cyc);
            if (exp_q_a.size() == 0) check("a_unexpected_beat", 128'(exp_q_a.size()), 128'd1);
            else                     check("a_beat", got_a, exp_q_a.pop_front());
        end
        if (!rst && bus_b.out_valid && bus_b.out_ready) begin
            got_b = {bus_b.out_last, bus_b.out_sat, bus_b.out_coef};
            obs_b.push_back(got_b);
            if (exp_q_b.size() == 0) check("b_unexpected_beat", 128'(exp_q_b.size()), 128'd1);
            else                     check("b_beat", got_b, exp_q_b.pop_front());
        end
    end

    task automatic drive_a(input logic [15:0] c, input logic [5:0] qp, input logic dc);
        int budget;
        longint d;
        bit s;
        bus_a.in_valid = 1'b1;
        bus_a.in_coef  = c;
        bus_a.in_qp    = qp;
        bus_a.in_dc    = dc;
        budget = 200;
        @(negedge clk);
        while (!bus_a.in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!bus_a.in_ready) begin
            check("a_accept_timeout", 128'(bus_a.in_ready), 128'd1);
        end else begin
            acc_cyc_a = cyc;
            if (beat_a == 0) begin
                blk_qp_a = int'(qp);
                blk_dc_a = dc;
            end
            model(longint'($signed(c)), beat_a, blk_qp_a, blk_dc_a, OWA, d, s);
            exp_q_a.push_back({beat_a == 15, s, d[15:0]});
            beat_a = (beat_a + 1) % 16;
        end
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic drive_b(input logic [63:0] c, input logic [5:0] qp, input logic dc);
        int budget;
        longint d;
        bit s, any;
        logic [95:0] ec;
        bus_b.in_valid = 1'b1;
        bus_b.in_coef  = c;
        bus_b.in_qp    = qp;
        bus_b.in_dc    = dc;
        budget = 200;
        @(negedge clk);
        while (!bus_b.in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!bus_b.in_ready) begin
            check("b_accept_timeout", 128'(bus_b.in_ready), 128'd1);
        end else begin
            acc_b++;
            if (beat_b == 0) begin
                blk_qp_b = int'(qp);
                blk_dc_b = dc;
            end
            any = 1'b0;
            for (int l = 0; l < 4; l++) begin
                model(longint'($signed(c[l*16 +: 16])), beat_b * 4 + l, blk_qp_b, blk_dc_b, OWB, d, s);
                ec[l*24 +: 24] = d[23:0];
                any = any | s;
            end
            exp_q_b.push_back({beat_b == 3, any, ec});
            beat_b = (beat_b + 1) % 4;
        end
        @(posedge clk);
        #1;
        bus_b.in_valid = 1'b0;
    endtask

    task automatic block_a(input int cf[16], input logic [5:0] qp, input logic dc);
        for (int i = 0; i < 16; i++) drive_a(16'(cf[i]), qp, dc);
    endtask

    task automatic drain();
        int budget;
        budget = 3000;
        while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) check("drain_timeout", 128'(exp_q_a.size() + exp_q_b.size()), 128'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic int count_last_a();
        int n = 0;
        foreach (obs_a[i]) n += int'(obs_a[i][17]);
        return n;
    endfunction

    initial begin
        int cf[16];
        bus_a.in_valid = 1'b0; bus_a.in_coef = '0; bus_a.in_qp = '0; bus_a.in_dc = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_coef = '0; bus_b.in_qp = '0; bus_b.in_dc = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_a_out_valid", 128'(bus_a.out_valid), 128'd0);
        check("rst_a_out_coef",  128'(bus_a.out_coef),  128'd0);
        check("rst_a_last_sat",  128'({bus_a.out_last, bus_a.out_sat}), 128'd0);
        check("rst_b_out_valid", 128'(bus_b.out_valid), 128'd0);
        check("rst_b_out_coef",  128'(bus_b.out_coef),  128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready_a", 128'(bus_a.in_ready), 128'd1);
        check("post_rst_in_ready_b", 128'(bus_b.in_ready), 128'd1);
        @(posedge clk);
        #1;

        // AC qp=0, all ones: raster pattern, single last, 2-cycle latency, back-to-back outputs
        obs_a.delete();
        obs_cyc_a.delete();
        for (int i = 0; i < 16; i++) cf[i] = 1;
        block_a(cf, 6'd0, 1'b0);
        drain();
        check("ac0_count", 128'(obs_a.size()), 128'd16);
        check("ac0_p0", 128'(obs_a[0][15:0]), 128'd10);
        check("ac0_p1", 128'(obs_a[1][15:0]), 128'd13);
        check("ac0_p4", 128'(obs_a[4][15:0]), 128'd13);
        check("ac0_p5", 128'(obs_a[5][15:0]), 128'd16);
        check("ac0_last_p15", 128'(obs_a[15][17]), 128'd1);
        check("ac0_last_count", 128'(count_last_a()), 128'd1);
        check("ac0_latency", 128'(obs_cyc_a[15] - acc_cyc_a), 128'd2);
        check("ac0_throughput", 128'(obs_cyc_a[15] - obs_cyc_a[0]), 128'd15);

        // AC qp=28
        obs_a.delete();
        for (int i = 0; i < 16; i++) cf[i] = 0;
        cf[0] = 3; cf[1] = 3; cf[5] = 3;
        block_a(cf, 6'd28, 1'b0);
        cf[0] = -3; cf[1] = 0; cf[5] = 0;
        block_a(cf, 6'd28, 1'b0);
        drain();
        check("ac28_p0", 128'(obs_a[0][15:0]), 128'd768);
        check("ac28_p1", 128'(obs_a[1][15:0]), 128'd960);
        check("ac28_p5", 128'(obs_a[5][15:0]), 128'd1200);
        check("ac28_neg_p0", 128'(obs_a[16][15:0]), 128'hFD00);

        // DC mode
        obs_a.delete();
        for (int i = 0; i < 16; i++) cf[i] = 0;
        cf[0] = 5; cf[1] = -5;
        block_a(cf, 6'd6, 1'b1);
        cf[1] = 0;
        block_a(cf, 6'd18, 1'b1);
        cf[0] = 1;
        block_a(cf, 6'd60, 1'b1);
        drain();
        check("dc6_pos",  128'(obs_a[0][15:0]), 128'd25);
        check("dc6_neg",  128'(obs_a[1][15:0]), 128'hFFE7);
        check("dc18",     128'(obs_a[16][15:0]), 128'd100);
        check("dc60_clamp", 128'(obs_a[32][15:0]), 128'd896);

        // Saturation at qp=51, OUT_W=16
        obs_a.delete();
        for (int i = 0; i < 16; i++) cf[i] = 0;
        cf[0] = 32767; cf[1] = -32768;
        block_a(cf, 6'd51, 1'b0);
        drain();
        check("sat_pos", 128'(obs_a[0][16:0]), 128'h17FFF);
        check("sat_neg", 128'(obs_a[1][16:0]), 128'h18000);
        check("sat_zero", 128'(obs_a[2][16:0]), 128'h00000);

        // Backpressure on LANES=4: two beats absorbed, then in_ready drops
        obs_b.delete();
        acc_b = 0;
        rdy_mode_b = 2;
        bus_b.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) drive_b({$urandom, $urandom}, 6'd20, 1'b0);
            end
        join_none
        repeat (5) @(negedge clk);
        check("hs_absorbed", 128'(acc_b), 128'd2);
        check("hs_in_ready_low", 128'(bus_b.in_ready), 128'd0);
        @(posedge clk);
        #1;
        rdy_mode_b = 0;
        bus_b.out_ready = 1'b1;
        wait fork;
        drain();
        check("hs_count", 128'(obs_b.size()), 128'd4);
        check("hs_last_bits", 128'({obs_b[0][97], obs_b[1][97], obs_b[2][97], obs_b[3][97]}), 128'b0001);

        // Random traffic, LANES=4, 100 blocks, 50% out_ready
        rdy_mode_b = 1;
        for (int b = 0; b < 100; b++) begin
            logic [5:0] qp;
            logic       dc;
            qp = 6'($urandom_range(0, 63));
            dc = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                drive_b({$urandom, $urandom}, ($urandom_range(0, 1) != 0) ? qp : 6'($urandom_range(0, 63)),
                        (i == 0) ? dc : 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain();
        rdy_mode_b = 0;

        // Random traffic, LANES=1, OUT_W=16 so saturation is frequent
        rdy_mode_a = 1;
        for (int b = 0; b < 12; b++) begin
            logic [5:0] qp;
            logic       dc;
            qp = 6'($urandom_range(0, 63));
            dc = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) drive_a(16'($urandom), qp, dc);
        end
        drain();
        rdy_mode_a = 0;

        // Reset mid-block, then a fresh qp=28 block
        for (int i = 0; i < 8; i++) drive_a(16'd1, 6'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 128'(bus_a.out_valid), 128'd0);
        exp_q_a.delete();
        beat_a = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs_a.delete();
        for (int i = 0; i < 16; i++) cf[i] = 1;
        cf[0] = 3;
        block_a(cf, 6'd28, 1'b0);
        drain();
        check("midrst_count", 128'(obs_a.size()), 128'd16);
        check("midrst_p0", 128'(obs_a[0][15:0]), 128'd768);
        check("midrst_last_p15", 128'(obs_a[15][17]), 128'd1);
        check("midrst_last_count", 128'(count_last_a()), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d outstanding expected 0",
                 exp_q_a.size() + exp_q_b.size());
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
